// File: rtl/mpu_matrix_loader.sv
// Matrix loader for the determinant stage: takes an order byte followed by n*n
// signed elements (row-major) and holds the zero-padded 5x5 matrix until consumed.
module mpu_matrix_loader (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [199:0] matrix,
    output logic [7:0]   size,
    output logic         matrix_valid,
    input  logic         matrix_ready,
    output logic         busy,
    output logic         size_error
);

    localparam int N = 5;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             size_q, size_d;
    logic [2:0]             row_q, row_d;
    logic [2:0]             col_q, col_d;
    logic                   err_q, err_d;
    logic [N*N-1:0][7:0]    mat_q;

    logic                   xfer;
    logic                   order_ok;
    logic                   last_col;
    logic                   last_row;
    logic                   clr;
    logic                   ld;

    assign in_ready     = (state_q != HOLD);
    assign xfer         = in_valid && in_ready;
    assign order_ok     = ($signed(in_data) >= 8'sd2) && ($signed(in_data) <= 8'sd5);
    // Only meaningful in LOAD, where size_q is always 2..5.
    assign last_col     = (col_q == size_q[2:0] - 3'd1);
    assign last_row     = (row_q == size_q[2:0] - 3'd1);

    assign matrix       = mat_q;
    assign size         = size_q;
    assign matrix_valid = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign size_error   = err_q;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = 1'b0;
        clr     = 1'b0;
        ld      = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (order_ok) begin
                        size_d  = in_data;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        clr     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    ld = 1'b1;
                    if (last_col) begin
                        col_d = 3'd0;
                        // Wrap row on the final element so it never reaches size.
                        if (last_row) begin
                            row_d   = 3'd0;
                            state_d = HOLD;
                        end else begin
                            row_d   = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (matrix_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            size_q  <= 8'd0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    mat_q[c+N*r] <= 8'd0;
                end else if (clr) begin
                    mat_q[c+N*r] <= 8'd0;
                end else if (ld && row_q == 3'(r) && col_q == 3'(c)) begin
                    mat_q[c+N*r] <= in_data;
                end
            end
        end
    end

endmodule
